// File: rtl/radio_arbiter.sv
// radio_arbiter
// RC receiver front end and command arbiter. Every channel's PWM pulse is
// measured on the 1 MHz timebase. Each pulse is checked against the glitch
// window and mapped to a 10-bit command. Once per cycle the block chooses
// between radio (manual) commands, autopilot commands and fixed failsafe
// commands.
//
// Ports:
//   clk_1M      1 MHz clock, rising edge
//   rst         synchronous active-high reset
//   radio       raw asynchronous PWM pins, bit i = channel i
//   auto_cmd    autopilot commands, channel i at [10i+9:10i]
//   auto_valid  autopilot commands are current
//   cmd         arbitrated commands, same packing as auto_cmd
//   mode        0 FAILSAFE, 1 MANUAL, 2 AUTO
//   stale       per-channel link timeout flags
//   upd         one-cycle pulse per channel on an accepted pulse
module radio_arbiter #(
    parameter int NCH        = 4,
    parameter int MIN_US     = 987,
    parameter int MAX_US     = 2010,
    parameter int GLITCH_LO  = 800,
    parameter int GLITCH_HI  = 2200,
    parameter int TIMEOUT_US = 50000,
    parameter int SW_HI      = 640,
    parameter int SW_LO      = 384
) (
    input  logic                clk_1M,
    input  logic                rst,
    input  logic [NCH-1:0]      radio,
    input  logic [10*NCH-1:0]   auto_cmd,
    input  logic                auto_valid,
    output logic [10*NCH-1:0]   cmd,
    output logic [1:0]          mode,
    output logic [NCH-1:0]      stale,
    output logic [NCH-1:0]      upd
);

    localparam logic [1:0]  ST_FAILSAFE = 2'd0;
    localparam logic [1:0]  ST_MANUAL   = 2'd1;
    localparam logic [1:0]  ST_AUTO     = 2'd2;

    localparam logic [11:0] GLO_W  = 12'(GLITCH_LO);
    localparam logic [11:0] GHI_W  = 12'(GLITCH_HI);
    localparam logic [11:0] MIN_W  = 12'(MIN_US);
    localparam logic [11:0] MAX_W  = 12'(MAX_US);
    localparam logic [9:0]  MIN_LO = 10'(MIN_US);
    localparam logic [15:0] TMO_W  = 16'(TIMEOUT_US);
    localparam logic [9:0]  SWH_W  = 10'(SW_HI);
    localparam logic [9:0]  SWL_W  = 10'(SW_LO);

    logic [NCH-1:0][9:0]  w_rcmd;
    logic [NCH-1:0]       w_upd;
    logic [NCH-1:0]       w_stale;
    logic [1:0]           w_mode_next;
    logic [10*NCH-1:0]    w_cmd_next;
    logic [10*NCH-1:0]    w_fs_cmd;

    logic [1:0]           r_mode;
    logic [10*NCH-1:0]    r_cmd;
    logic                 r_sw;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic        r_s1, r_s2, r_s3;
            logic        r_run;
            logic [11:0] r_width;
            logic [15:0] r_tmo;
            logic [9:0]  r_rcmd;
            logic        r_upd;
            logic        w_rise, w_fall, w_ok;
            logic [9:0]  w_off;

            assign w_rise = r_s2 & ~r_s3;
            assign w_fall = ~r_s2 & r_s3;
            // Accept only a pulse whose rise was actually observed. A pulse
            // that was already high when reset released is ignored.
            assign w_ok   = w_fall & r_run & (r_width >= GLO_W) & (r_width < GHI_W);
            // The offset is at most 1023 whenever it is used, so modulo-1024
            // arithmetic on the low bits is exact.
            assign w_off  = r_width[9:0] - MIN_LO;

            always_ff @(posedge clk_1M) begin
                if (rst) begin
                    // The synchroniser is preset high. A rise therefore needs
                    // a genuine low level seen after reset.
                    r_s1    <= 1'b1;
                    r_s2    <= 1'b1;
                    r_s3    <= 1'b1;
                    r_run   <= 1'b0;
                    r_width <= '0;
                    r_tmo   <= TMO_W;
                    r_rcmd  <= '0;
                    r_upd   <= 1'b0;
                end else begin
                    r_s1  <= radio[gi];
                    r_s2  <= r_s1;
                    r_s3  <= r_s2;
                    r_upd <= w_ok;

                    if (w_rise) begin
                        r_run   <= 1'b1;
                        r_width <= 12'd1;
                    end else begin
                        if (w_fall)
                            r_run <= 1'b0;
                        if (r_run && r_s2 && (r_width != 12'hFFF))
                            r_width <= r_width + 12'd1;
                    end

                    if (w_ok) begin
                        r_tmo <= '0;
                        if (r_width < MIN_W)
                            r_rcmd <= 10'd0;
                        else if (r_width > MAX_W)
                            r_rcmd <= 10'd1023;
                        else
                            r_rcmd <= w_off;
                    end else if (r_tmo != 16'hFFFF) begin
                        r_tmo <= r_tmo + 16'd1;
                    end
                end
            end

            assign w_rcmd[gi]  = r_rcmd;
            assign w_upd[gi]   = r_upd;
            assign w_stale[gi] = (r_tmo >= TMO_W);
        end
    endgenerate

    // Mode request register with hysteresis on the mode-switch channel.
    always_ff @(posedge clk_1M) begin
        if (rst)
            r_sw <= 1'b0;
        else if (w_rcmd[NCH-1] >= SWH_W)
            r_sw <= 1'b1;
        else if (w_rcmd[NCH-1] <= SWL_W)
            r_sw <= 1'b0;
    end

    always_comb begin
        w_mode_next = r_mode;
        if (|w_stale) begin
            w_mode_next = ST_FAILSAFE;
        end else begin
            case (r_mode)
                ST_FAILSAFE: if (w_upd[0])               w_mode_next = ST_MANUAL;
                ST_MANUAL:   if (r_sw && auto_valid)     w_mode_next = ST_AUTO;
                ST_AUTO:     if (!r_sw || !auto_valid)   w_mode_next = ST_MANUAL;
                default:                                 w_mode_next = ST_FAILSAFE;
            endcase
        end
    end

    // The command is chosen from the next-state mode. This way a mode change
    // and the commands for the new mode land on the same edge.
    always_comb begin
        w_fs_cmd   = '0;
        w_cmd_next = '0;
        for (int i = 0; i < NCH; i++) begin
            w_fs_cmd[10*i +: 10] = (i == 0) ? 10'd0 : 10'd512;
            case (w_mode_next)
                ST_MANUAL: w_cmd_next[10*i +: 10] = w_rcmd[i];
                ST_AUTO:   w_cmd_next[10*i +: 10] = (i == NCH-1) ? w_rcmd[i]
                                                                 : auto_cmd[10*i +: 10];
                default:   w_cmd_next[10*i +: 10] = (i == 0) ? 10'd0 : 10'd512;
            endcase
        end
    end

    always_ff @(posedge clk_1M) begin
        if (rst) begin
            r_mode <= ST_FAILSAFE;
            r_cmd  <= w_fs_cmd;
        end else begin
            r_mode <= w_mode_next;
            r_cmd  <= w_cmd_next;
        end
    end

    assign cmd   = r_cmd;
    assign mode  = r_mode;
    assign stale = w_stale;
    assign upd   = w_upd;

endmodule

// File: tb/tb_radio_arbiter.sv
`timescale 1ns/1ns
// tb_radio_arbiter
// Directed frames of PWM pulses. Each accepted pulse pushes its hand-computed
// command and mode into a queue. The monitor pops an entry on every upd
// pulse and checks cmd and mode one edge later.
module tb_radio_arbiter;

    localparam int GAP = 200;

    logic        clk_1M = 1'b0;
    logic        rst;
    logic [3:0]  radio;
    logic [39:0] auto_cmd;
    logic        auto_valid;
    logic [39:0] cmd;
    logic [1:0]  mode;
    logic [3:0]  stale;
    logic [3:0]  upd;

    radio_arbiter dut (
        .clk_1M     (clk_1M),
        .rst        (rst),
        .radio      (radio),
        .auto_cmd   (auto_cmd),
        .auto_valid (auto_valid),
        .cmd        (cmd),
        .mode       (mode),
        .stale      (stale),
        .upd        (upd)
    );

    always #500 clk_1M = ~clk_1M;

    typedef struct {
        int ch;
        int cmdv;
        int md;
    } exp_t;

    exp_t q[$];
    exp_t pend [4];
    bit   pend_v [4];
    int   last_upd [4];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    // Monitor: count cycles, pop one expectation per upd, check it next edge.
    initial begin
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            pend_v[i]   = 0;
            last_upd[i] = 0;
        end
        forever begin
            @(posedge clk_1M);
            #1;
            cyc++;
            for (int i = 0; i < 4; i++) begin
                if (pend_v[i]) begin
                    chk($sformatf("cmd_ch%0d", i), longint'(cmd[10*i +: 10]), pend[i].cmdv);
                    chk($sformatf("mode_after_upd_ch%0d", i), longint'(mode), pend[i].md);
                    $display("txn: ch%0d cmd=%0d mode=%0d (exp %0d/%0d)",
                             i, cmd[10*i +: 10], mode, pend[i].cmdv, pend[i].md);
                    pend_v[i] = 0;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (upd[i]) begin
                    last_upd[i] = cyc;
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_upd ch%0d: got upd=1, required 0", i);
                    end else begin
                        e = q.pop_front();
                        chk("upd_channel", i, e.ch);
                        pend[i]   = e;
                        pend_v[i] = 1;
                    end
                end
            end
        end
    end

    // Drive one frame. All masked channels rise together and each falls after
    // its own width. An accepted channel pushes its expectation when it falls.
    task automatic frame(input int w [4], input logic [3:0] mask, input logic [3:0] acc,
                         input int ec [4], input int em [4]);
        int mx;
        exp_t e;
        mx = 0;
        for (int i = 0; i < 4; i++)
            if (mask[i] && w[i] > mx) mx = w[i];
        for (int t = 0; t < mx + GAP; t++) begin
            @(negedge clk_1M);
            for (int i = 0; i < 4; i++) begin
                radio[i] = mask[i] && (t < w[i]);
                if (mask[i] && acc[i] && t == w[i]) begin
                    e.ch = i; e.cmdv = ec[i]; e.md = em[i];
                    q.push_back(e);
                end
            end
        end
    endtask

    task automatic ch1(input int w, input bit acc, input int ec);
        frame('{0, w, 0, 0}, 4'b0010, {2'b00, acc, 1'b0}, '{0, ec, 0, 0}, '{1, 1, 1, 1});
    endtask

    task automatic tick;
        @(posedge clk_1M);
        #2;
    endtask

    initial begin
        int target;
        rst        = 1'b1;
        radio      = 4'b0000;
        auto_valid = 1'b0;
        auto_cmd   = {4{10'd300}};
        repeat (3) tick();
        chk("reset_mode", mode, 0);
        chk("reset_cmd", cmd, {10'd512, 10'd512, 10'd512, 10'd0});
        chk("reset_stale", stale, 4'hF);
        chk("reset_upd", upd, 0);
        @(negedge clk_1M);
        rst = 1'b0;

        // First frame: FAILSAFE -> MANUAL on the ch0 update.
        frame('{1500, 1500, 1500, 1500}, 4'hF, 4'hF, '{513, 513, 513, 513}, '{1, 1, 1, 1});
        chk("stale_after_first_frame", stale, 0);

        // Mapping and clamping on ch1; rejected pulses leave the value alone.
        ch1(987, 1, 0);
        ch1(2010, 1, 1023);
        ch1(950, 1, 0);
        ch1(2100, 1, 1023);
        ch1(700, 0, 0);
        chk("held_after_700", cmd[19:10], 1023);
        ch1(2300, 0, 0);
        chk("held_after_2300", cmd[19:10], 1023);
        ch1(810, 1, 0);
        ch1(2210, 0, 0);
        chk("held_after_2210", cmd[19:10], 0);
        frame('{1500, 1500, 1500, 1500}, 4'hF, 4'hF, '{513, 513, 513, 513}, '{1, 1, 1, 1});

        // Enter AUTO through the mode switch, then leave it again.
        auto_valid = 1'b1;
        frame('{1500, 1500, 1500, 1700}, 4'hF, 4'hF, '{513, 513, 513, 713}, '{1, 1, 1, 1});
        chk("auto_mode", mode, 2);
        chk("auto_cmd", cmd, {10'd713, 10'd300, 10'd300, 10'd300});
        frame('{1500, 1500, 1500, 1500}, 4'hF, 4'hF, '{300, 300, 300, 513}, '{2, 2, 2, 2});
        frame('{1500, 1500, 1500, 1300}, 4'hF, 4'hF, '{513, 513, 513, 313}, '{1, 1, 1, 2});
        chk("manual_after_sw_low", mode, 1);
        frame('{1500, 1500, 1500, 1700}, 4'hF, 4'hF, '{513, 513, 513, 713}, '{1, 1, 1, 1});
        chk("auto_again", mode, 2);

        // auto_cmd reaches cmd one edge after it changes.
        @(negedge clk_1M);
        auto_cmd[9:0] = 10'd123;
        tick();
        chk("auto_latency", cmd, {10'd713, 10'd300, 10'd300, 10'd123});
        @(negedge clk_1M);
        auto_valid = 1'b0;
        tick();
        chk("drop_valid_mode", mode, 1);
        chk("drop_valid_cmd", cmd, {10'd713, 10'd513, 10'd513, 10'd513});

        // Stop ch2 and time its stale flag against its last update.
        frame('{1500, 1500, 0, 1500}, 4'b1011, 4'b1011, '{513, 513, 0, 513}, '{1, 1, 1, 1});
        target = last_upd[2] + 49999;
        while (cyc < target) tick();
        chk("stale_minus1", stale, 0);
        tick();
        chk("stale_at_timeout", stale, 4'b0100);
        chk("mode_at_timeout", mode, 1);
        tick();
        chk("failsafe_mode", mode, 0);
        chk("failsafe_cmd", cmd, {10'd512, 10'd512, 10'd512, 10'd0});

        // With sw set and auto_valid high, recovery still passes through MANUAL.
        @(negedge clk_1M);
        auto_valid = 1'b1;
        repeat (2500) tick();
        chk("all_stale", stale, 4'hF);
        chk("still_failsafe", mode, 0);
        frame('{1500, 1500, 1500, 1500}, 4'hF, 4'hF, '{513, 513, 513, 513}, '{1, 1, 1, 1});
        chk("auto_after_resume", mode, 2);
        chk("auto_after_resume_cmd", cmd, {10'd513, 10'd300, 10'd300, 10'd123});

        // Reset in the middle of a pulse; the truncated pulse must not update.
        for (int t = 0; t < 1500 + 300; t++) begin
            @(negedge clk_1M);
            radio = (t < 1500) ? 4'hF : 4'h0;
            if (t == 700) begin
                rst = 1'b1;
                tick();
                chk("midreset_mode", mode, 0);
                chk("midreset_cmd", cmd, {10'd512, 10'd512, 10'd512, 10'd0});
                chk("midreset_stale", stale, 4'hF);
                chk("midreset_upd", upd, 0);
            end else begin
                rst = 1'b0;
            end
        end
        chk("post_reset_mode", mode, 0);
        chk("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #(64'd1000 * 64'd98000);
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: got cycle %0d, required finish before 98000", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/radio_arbiter.md
# radio_arbiter

Multi-channel RC receiver front end and command arbiter. Measures NCH PWM channels from the RC receiver on the 1 MHz timebase, validates and normalises each pulse to a 10-bit command, and selects per frame between radio (manual) commands and autopilot commands. Sits between the receiver pins and the motor/servo mixer; drops to fixed failsafe commands when the link goes stale.

## Interface
- NCH, 4: number of channels; channel NCH-1 is the mode switch.
- MIN_US, 987: pulse width mapping to command 0.
- MAX_US, 2010: pulse width mapping to command 1023 (MAX_US-MIN_US must equal 1023).
- GLITCH_LO, 800: shorter pulses are rejected.
- GLITCH_HI, 2200: pulses of this width or longer are rejected.
- TIMEOUT_US, 50000: cycles without an accepted pulse before a channel is stale.
- SW_HI, 640 / SW_LO, 384: mode-switch hysteresis thresholds on the 10-bit command.
- clk_1M  input  1  1 MHz clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- radio  input  NCH  raw asynchronous PWM pins, bit i = channel i.
- auto_cmd  input  10*NCH  autopilot commands, channel i at [10i+9:10i].
- auto_valid  input  1  autopilot commands are current.
- cmd  output  10*NCH  arbitrated commands, same packing as auto_cmd.
- mode  output  2  0 FAILSAFE, 1 MANUAL, 2 AUTO.
- stale  output  NCH  per-channel timeout flags.
- upd  output  NCH  one-cycle pulse: channel i accepted a new pulse.

## Operation
- Per channel: 2-FF synchroniser (s1, s2) plus delayed copy s3; rise = s2 & ~s3, fall = ~s2 & s3.
- Width counter, 12 bits: cleared to 1 on rise, +1 each cycle s2 high, saturates at 4095.
- On fall: width w accepted iff GLITCH_LO <= w < GLITCH_HI. Accepted: radio_cmd[i] <= 0 if w < MIN_US, 1023 if w > MAX_US, else w - MIN_US (10 bits, no wrap); upd[i] pulses; timeout counter cleared. Rejected: radio_cmd[i], timeout untouched, no upd.
- Timeout counter, 16 bits, +1 per cycle, saturates at 65535; stale[i] = (counter >= TIMEOUT_US).
- Mode request register sw: set when radio_cmd[NCH-1] >= SW_HI, cleared when <= SW_LO, holds in between.
- FSM (mode), priority top-down each cycle:
  - any stale -> FAILSAFE.
  - FAILSAFE: no stale and upd[0] -> MANUAL (always re-enter via MANUAL).
  - MANUAL: sw & auto_valid -> AUTO.
  - AUTO: ~sw | ~auto_valid -> MANUAL.
- cmd register: FAILSAFE: channel 0 = 0, all others = 512. MANUAL: radio_cmd. AUTO: auto_cmd, except channel NCH-1 = radio_cmd[NCH-1].
- Reset: all counters, radio_cmd = 0, sw = 0, stale = all ones (timeout counters preset to TIMEOUT_US), upd = 0, mode = FAILSAFE, cmd = failsafe values.

## Timing
- Pin fall sampled at edge k: s2 low at k+1, radio_cmd/upd/timeout at k+2, mode and cmd at k+3.
- Measured w equals pulse width in µs within ±1.
- mode change and cmd for the new mode appear on the same edge (cmd computed from next-state mode).
- Stale asserts exactly TIMEOUT_US cycles after the last accepted upd; FAILSAFE on the following edge.
- auto_cmd is sampled every cycle in AUTO; no handshake, one-cycle latency to cmd.
- Simultaneous rise and fall on different channels are independent; a rise in the same cycle as a rejected fall on the same channel restarts counting normally.
- rst asserted mid-pulse: pulse in progress is discarded; first pulse measured starts from a fresh rise after rst deasserts.

## Test plan
- Reset, then 1500 µs pulses every 20 ms on all channels -> upd on each, radio_cmd = 513, mode FAILSAFE -> MANUAL after first ch0 upd, cmd = 513 each.
- Widths 987, 2010, 950, 2100 on ch1 -> radio_cmd 0, 1023, 0, 1023; widths 700 and 2300 -> no upd, value held.
- Ch3 width 1700 (cmd 713) with auto_valid=1, auto_cmd all 300 -> AUTO, cmd ch0-2 = 300, ch3 = 713; ch3 width 1500 (513) -> stays AUTO; width 1300 (313) -> MANUAL.
- In AUTO drop auto_valid -> MANUAL on next edge, cmd = radio_cmd.
- Stop ch2 pulses -> stale[2] exactly 50000 cycles after last upd, mode FAILSAFE, cmd = {512,512,512,0}; resume -> MANUAL on next ch0 upd, never directly AUTO.
- Assert rst mid 1500 µs pulse -> all outputs to reset values next edge; truncated pulse produces no upd.
